// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
//   state_t   : arbitration/service FSM states
//   MISSED_W  : width of the optional missed-edge counter
//   N_SRC_DEF : default number of interrupt sources
//   ID_W_DEF  : default width of the source ID
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int MISSED_W  = 8;
    localparam int N_SRC_DEF = 4;
    localparam int ID_W_DEF  = 2;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side request/acknowledge handshake of the interrupt controller.
//   irq    : request to the CPU
//   irq_id : index of the source being requested or serviced
//   iack   : CPU acknowledge, single-cycle pulse
//   eoi    : CPU end-of-interrupt, single-cycle pulse
// master = CPU side, slave = controller side.
interface irq_controller_if #(
    parameter int ID_W = irq_pkg::ID_W_DEF
);
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic            iack;
    logic            eoi;

    modport master (input irq, input irq_id, output iack, output eoi);
    modport slave  (output irq, output irq_id, input iack, input eoi);
endinterface

// File: rtl/irq_edge_det.sv
// Per-bit rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig        : input vector (synchronous to clk)
//   rise       : sig & ~previous sig, combinational
// History resets to 0, so a bit already high when reset releases is
// reported as an edge on the first clock.
module irq_edge_det #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sig,
    output logic [W-1:0] rise
);
    logic [W-1:0] prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= sig;
    end

    assign rise = sig & ~prev;
endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with iack/eoi handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq_in     : source lines (bit 0 = periodic timer pulse)
//   mask       : 1 = source excluded from arbitration (still latched)
//   pending    : latched pending bits
//   busy       : high while an interrupt is in service
//   bus        : irq/irq_id/iack/eoi handshake (slave side)
//   missed_cnt : saturating count of edges merged into an existing
//                request; present only when IRQ_MISSED_CNT_EN is defined
// Rising edges set pending bits; the lowest unmasked pending index wins.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SRC-1:0]    irq_in,
    input  logic [N_SRC-1:0]    mask,
    output logic [N_SRC-1:0]    pending,
    output logic                busy,
    irq_controller_if.slave     bus
`ifdef IRQ_MISSED_CNT_EN
    ,
    output logic [MISSED_W-1:0] missed_cnt
`endif
);
    state_t          state;
    logic            irq_q;
    logic [ID_W-1:0] irq_id_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;

    // Lowest set index wins; scanning downward lets lower bits overwrite.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    irq_edge_det #(.W(N_SRC)) u_edge_det (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (irq_in),
        .rise (rise)
    );

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        clr = '0;
        if (state == REQ && bus.iack) clr[irq_id_q] = 1'b1;
    end

    assign eligible = pending & ~mask;

    // A new edge on the bit being acknowledged survives as a fresh request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        irq_id_q <= lowest_set(eligible);
                        irq_q    <= 1'b1;
                        state    <= REQ;
                    end
                end
                // Request is never retracted; iack takes precedence over eoi.
                REQ: begin
                    if (bus.iack) begin
                        irq_q <= 1'b0;
                        busy  <= 1'b1;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irq    = irq_q;
    assign bus.irq_id = irq_id_q;

`ifdef IRQ_MISSED_CNT_EN
    logic [N_SRC-1:0]  lost;
    logic [MISSED_W:0] missed_sum;

    // An edge is lost when its bit is already pending and not being cleared.
    assign lost       = rise & pending & ~clr;
    assign missed_sum = {1'b0, missed_cnt} + (MISSED_W + 1)'($countones(lost));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               missed_cnt <= '0;
        else if (missed_sum[MISSED_W]) missed_cnt <= '1;
        else                      missed_cnt <= missed_sum[MISSED_W-1:0];
    end
`endif
endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller. Inputs change 1 time unit
// after a rising clock edge; outputs are sampled at the same offset after
// the following edge.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    logic             clk;
    logic             rst_n;
    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic             busy;
`ifdef IRQ_MISSED_CNT_EN
    logic [MISSED_W-1:0] missed_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    irq_controller_if #(.ID_W(ID_W)) bus ();

    irq_controller #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask      (mask),
        .pending   (pending),
        .busy      (busy),
        .bus       (bus.slave)
`ifdef IRQ_MISSED_CNT_EN
        ,
        .missed_cnt(missed_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack();
        bus.iack = 1'b1;
        tick();
        bus.iack = 1'b0;
    endtask

    task automatic end_irq();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_in   = '0;
        mask     = '0;
        bus.iack = 1'b0;
        bus.eoi  = 1'b0;
        repeat (2) tick();
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_id", 32'(bus.irq_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // iack/eoi outside their states are ignored.
        ack();
        check("stray_iack_busy", 32'(busy), 0);
        end_irq();
        check("stray_eoi_irq", 32'(bus.irq), 0);

        // Timer pulse: 5 cycles high on bit 0 -> one request only.
        irq_in = 4'b0001;
        tick();
        check("t1_pending", 32'(pending), 32'h1);
        check("t1_irq_early", 32'(bus.irq), 0);
        tick();
        check("t1_irq", 32'(bus.irq), 1);
        check("t1_id", 32'(bus.irq_id), 0);
        repeat (3) tick();
        irq_in = '0;
        check("t1_irq_held", 32'(bus.irq), 1);
        ack();
        check("t1_ack_irq", 32'(bus.irq), 0);
        check("t1_ack_busy", 32'(busy), 1);
        check("t1_ack_pending", 32'(pending), 0);
        end_irq();
        check("t1_eoi_busy", 32'(busy), 0);
        tick();
        check("t1_no_repeat", 32'(bus.irq), 0);

        // Simultaneous edges on 1 and 3; iack+eoi together only acks.
        irq_in = 4'b1010;
        tick();
        irq_in = '0;
        check("t2_pending", 32'(pending), 32'hA);
        tick();
        check("t2_id_first", 32'(bus.irq_id), 1);
        bus.eoi = 1'b1;
        ack();
        bus.eoi = 1'b0;
        check("t2_ack_wins_busy", 32'(busy), 1);
        check("t2_state", 32'(dut.state), 32'(SERVICE));
        check("t2_pending_left", 32'(pending), 32'h8);
        end_irq();
        tick();
        check("t2_irq_second", 32'(bus.irq), 1);
        check("t2_id_second", 32'(bus.irq_id), 3);
        ack();
        end_irq();
        check("t2_pending_done", 32'(pending), 0);

        // Masked source latches but does not request.
        mask   = 4'b0100;
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        check("t3_pending", 32'(pending), 32'h4);
        repeat (2) tick();
        check("t3_masked_irq", 32'(bus.irq), 0);
        mask = '0;
        tick();
        check("t3_unmask_irq", 32'(bus.irq), 1);
        check("t3_unmask_id", 32'(bus.irq_id), 2);
        ack();
        end_irq();

        // Set wins over clear on the iack cycle; edge during SERVICE re-latches.
        irq_in = 4'b0001;
        tick();
        tick();
        irq_in = '0;
        tick();
        check("t4_irq", 32'(bus.irq), 1);
        irq_in = 4'b0001;
        ack();
        irq_in = '0;
        check("t4_set_wins", 32'(pending), 32'h1);
        check("t4_busy", 32'(busy), 1);
        end_irq();
        tick();
        check("t4_second_irq", 32'(bus.irq), 1);
        check("t4_second_id", 32'(bus.irq_id), 0);
        ack();
        check("t4_cleared", 32'(pending), 0);
        irq_in = 4'b0001;
        tick();
        irq_in = '0;
        check("t4_svc_latch", 32'(pending), 32'h1);
        check("t4_svc_no_irq", 32'(bus.irq), 0);
        end_irq();
        tick();
        check("t4_third_irq", 32'(bus.irq), 1);
        check("t4_third_id", 32'(bus.irq_id), 0);
        ack();
        end_irq();

        // Reset in REQ; a source high at release counts as an edge.
        irq_in = 4'b0010;
        tick();
        tick();
        irq_in = '0;
        check("t5_irq_before", 32'(bus.irq), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_irq", 32'(bus.irq), 0);
        check("t5_async_pending", 32'(pending), 0);
        check("t5_async_busy", 32'(busy), 0);
        irq_in = 4'b1000;
        tick();
        rst_n = 1'b1;
        check("t5_state_idle", 32'(dut.state), 32'(IDLE));
        tick();
        check("t5_release_edge", 32'(pending), 32'h8);
        tick();
        irq_in = '0;
        check("t5_release_irq", 32'(bus.irq), 1);
        check("t5_release_id", 32'(bus.irq_id), 3);
        ack();
        end_irq();

`ifdef IRQ_MISSED_CNT_EN
        check("m_start", 32'(missed_cnt), 0);
        mask   = 4'b0010;
        irq_in = 4'b0010;
        tick();
        irq_in = '0;
        tick();
        check("m_first_pending", 32'(pending), 32'h2);
        for (int i = 0; i < 3; i++) begin
            irq_in = 4'b0010;
            tick();
            irq_in = '0;
            tick();
        end
        check("m_cnt3", 32'(missed_cnt), 3);
        for (int i = 0; i < 297; i++) begin
            irq_in = 4'b0010;
            tick();
            irq_in = '0;
            tick();
        end
        check("m_cnt_sat", 32'(missed_cnt), 255);
        rst_n = 1'b0;
        #1;
        check("m_rst", 32'(missed_cnt), 0);
        tick();
        rst_n = 1'b1;
        mask  = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller directly downstream of the periodic timer; consumes its `inter` pulse, which stays high 5 cycles every 115 cycles, on source 0.
- Accepts up to N_SRC level/pulse sources and converts each rising edge into one latched pending request.
- Arbitrates by fixed priority (lowest index wins) and presents a single `irq` plus source ID to the CPU.
- Uses an iack/eoi handshake so that each pulse is serviced exactly once.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  input  1  system clock; shared with the timer, so all inputs are synchronous.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  N_SRC  source lines; bit 0 = timer `inter`.
- mask  input  N_SRC  1 = source excluded from arbitration; the pending bit is still latched.
- irq  output  1  interrupt request to CPU.
- irq_id  output  ID_W  index of the source being requested or serviced.
- iack  input  1  CPU acknowledge, single-cycle pulse.
- eoi  input  1  CPU end-of-interrupt, single-cycle pulse.
- pending  output  N_SRC  latched pending bits.
- busy  output  1  high while an interrupt is in service.

Behaviour:
- Reset (async assert, sync release): irq=0, irq_id=0, pending=0, busy=0, edge-history register=0, state=IDLE.
  - Because history resets to 0, a source already high at release counts as an edge on the first clock.
- Edge detect, per bit: edge[i] = irq_in[i] & ~prev[i], with prev registered every cycle.
  - A 5-cycle-high pulse yields exactly one edge.
- Pending: set on edge[i]; cleared only by iack for the current irq_id.
  - Simultaneous set and clear on the same bit: set wins, and the bit stays 1 as a new request.
- FSM, 3 states:
  - IDLE: if (pending & ~mask) != 0, then irq_id <= lowest set index, irq <= 1, go to REQ. Otherwise stay.
  - REQ: irq held high and irq_id frozen, even if the source becomes masked in the meantime (no retraction). On iack: pending[irq_id] <= 0, irq <= 0, busy <= 1, go to SERVICE.
  - SERVICE: no arbitration; new edges still latch into pending. On eoi: busy <= 0, go to IDLE. Re-arbitration happens on the next cycle, with no extra idle cycle required.
- Latency: edge sampled at posedge T gives pending visible after T. The IDLE arbitration at T+1 gives irq=1 after T+1. Timer high-start to irq high is therefore 2 cycles.
- Ignored inputs: iack outside REQ; eoi outside SERVICE. iack and eoi together in REQ: only iack acts.
- Throughput: minimum 3 cycles per serviced interrupt (IDLE→REQ→SERVICE→IDLE).
  - The timer period of 115 cycles leaves margin.
  - A second edge while the bit is still pending is lost, merged into the existing request.
- Reset asserted mid-REQ or mid-SERVICE: immediate return to reset values; in-flight requests are discarded.

Optional Feature:
- IRQ_MISSED_CNT_EN: when defined, adds output `missed_cnt` [7:0].
  - Counts edges on any source that arrive while that source's pending bit is already 1 and not being cleared that cycle.
  - The counter saturates at 255 and is cleared only by reset.
- When undefined, the port and logic are absent; merged edges are silently dropped.

Decomposition:
- Package irq_pkg holds:
  - the state enum {IDLE, REQ, SERVICE};
  - the localparam for MISSED_W = 8;
  - the default N_SRC/ID_W constants.
- Sub-module irq_edge_det: per-vector history register plus rising-edge output, instantiated once with width N_SRC.
- The priority encoder stays inline as a function.

Test Plan:
- Timer pulse on irq_in[0], high for cycles 100–104 → pending[0]=1 one cycle after the first high sample, irq=1 one cycle later, irq_id=0. Only one request, with no repeat during cycles 101–104.
- Simultaneous edges on bits 1 and 3 → irq_id=1 first. After iack and eoi, irq re-asserts with irq_id=3 within 1 cycle of IDLE.
- mask[2]=1 and edge on bit 2 → pending[2]=1, irq stays 0. Clear mask → irq=1, irq_id=2 on the next cycle.
- Edge on bit 0 during SERVICE of bit 0 → pending[0]=1 again. After eoi, a second request with irq_id=0. Also check set-vs-clear in the same cycle as iack: pending stays 1.
- Reset pulse while in REQ with irq=1 → irq, busy and pending go to 0 asynchronously, and the FSM is in IDLE after release.
- With IRQ_MISSED_CNT_EN defined: 3 extra edges on bit 1 while pending[1]=1 → missed_cnt=3. 300 such edges → missed_cnt=255 (saturated).
